// File: rtl/matrix_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_frame_decoder
//  Purpose  : Receive side of the 8x8 LED-matrix scan interface. Samples the
//             multiplexed row-select / column-data lines and rebuilds the
//             complete GS*GS frame bitmap. A row is accepted only after it has
//             been held unchanged for STABLE_CYC cycles.
//  Options  : FRAME_DECODER_TIMEOUT_EN - when defined, a capture that runs for
//             TIMEOUT cycles is aborted and the sticky err_o flag is raised.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_frame_decoder #(
    parameter int GS         = 8,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               e_cap_i,
    input  logic [GS-1:0]      row_i,
    input  logic [GS-1:0]      col_i,
    output logic [GS*GS-1:0]   matrix_o,
    output logic               d_cap_o,
    output logic               err_o
);

    localparam int              SW       = $clog2(STABLE_CYC + 1);
    localparam int              IW       = (GS > 1) ? $clog2(GS) : 1;
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Reject configurations the stability counter and timer cannot represent
    if (STABLE_CYC < 1 || TIMEOUT < 1) begin : g_param_check
        $error("matrix_frame_decoder: STABLE_CYC and TIMEOUT must be >= 1");
    end

    state_t             state_q;
    logic [GS-1:0]      row_q;
    logic [GS-1:0]      col_q;
    logic [GS-1:0]      seen_q;
    logic [SW-1:0]      stab_q;
    logic [SW-1:0]      stab_d;
    logic [GS*GS-1:0]   shadow_q;
    logic [GS*GS-1:0]   matrix_q;
    logic               d_cap_q;
    logic               same;
    logic               onehot;
    logic               accept;
    logic [IW-1:0]      row_idx;
    logic               tmr_expire;

    // Run-length of the current {row,col} sample and the one-shot accept strobe
    always_comb begin
        same = (row_i == row_q) && (col_i == col_q);
        if (same) begin
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
        end else begin
            stab_d = SW'(1);
        end
        onehot  = (row_i != '0) && ((row_i & (row_i - 1'b1)) == '0);
        row_idx = '0;
        for (int r = 0; r < GS; r++) begin
            if (row_i[r]) begin
                row_idx = IW'(r);
            end
        end
        // Fire only on the cycle the run first reaches STABLE_CYC; a saturated
        // run that simply continues must not be accepted again.
        accept = onehot && (stab_d == STAB_MAX) && !(same && (stab_q == STAB_MAX));
    end

`ifdef FRAME_DECODER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmr_q;
    logic          err_q;

    assign tmr_expire = (state_q == S_CAPTURE) && (tmr_q == TMR_LAST);
    assign err_o      = err_q;

    // Capture-duration counter, cleared whenever a new capture starts
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr_q <= '0;
        end else if (state_q == S_IDLE) begin
            tmr_q <= '0;
        end else if (state_q == S_CAPTURE && !tmr_expire) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // Sticky timeout flag, only cleared by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (tmr_expire) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmr_expire = 1'b0;
    assign err_o      = 1'b0;
`endif

    // Capture sequencer: sampling, row acceptance and frame hand-off
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            seen_q   <= '0;
            stab_q   <= '0;
            shadow_q <= '0;
            matrix_q <= '0;
            d_cap_q  <= 1'b0;
        end else begin
            row_q   <= row_i;
            col_q   <= col_i;
            d_cap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (e_cap_i) begin
                        state_q  <= S_CAPTURE;
                        seen_q   <= '0;
                        stab_q   <= '0;
                        shadow_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    // Abort has priority so a frame completing as enable
                    // drops is never published.
                    if (!e_cap_i || tmr_expire) begin
                        state_q <= S_IDLE;
                    end else if (&seen_q) begin
                        state_q  <= S_DONE;
                        d_cap_q  <= 1'b1;
                        matrix_q <= shadow_q;
                    end else begin
                        stab_q <= stab_d;
                        if (accept) begin
                            shadow_q[row_idx*GS +: GS] <= col_i;
                            seen_q[row_idx]            <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign matrix_o = matrix_q;
    assign d_cap_o  = d_cap_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_frame_decoder
//  Purpose  : Self-checking bench for matrix_frame_decoder. Stimulus is a list
//             of held {row,col} segments; the reference model derives the
//             expected frame and completion edge from segment lengths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_decoder;

    localparam int GS         = 8;
    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 64;

    logic               clk;
    logic               rst_n;
    logic               e_cap;
    logic [GS-1:0]      row;
    logic [GS-1:0]      col;
    logic [GS*GS-1:0]   matrix;
    logic               d_cap;
    logic               err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [GS-1:0]      q_row[$];
    logic [GS-1:0]      q_col[$];
    int                 q_len[$];
    logic [GS*GS-1:0]   prev_frame = '0;

    matrix_frame_decoder #(
        .GS         (GS),
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .e_cap_i  (e_cap),
        .row_i    (row),
        .col_i    (col),
        .matrix_o (matrix),
        .d_cap_o  (d_cap),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic int row_index(input logic [GS-1:0] v);
        int idx = 0;
        for (int i = 0; i < GS; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // Reference: a segment held >= STABLE_CYC cycles with a single active row
    // writes that row. Segment starting at edge s is accepted at edge
    // s+STABLE_CYC-1; returns the edge at which the last missing row lands.
    function automatic int model_eval(output logic [GS*GS-1:0] frame);
        logic [GS-1:0] seen = '0;
        int cum = 1;
        frame = '0;
        foreach (q_row[i]) begin
            if (q_len[i] >= STABLE_CYC && $countones(q_row[i]) == 1) begin
                int r = row_index(q_row[i]);
                frame[r*GS +: GS] = q_col[i];
                seen[r] = 1'b1;
                if (&seen) return cum + STABLE_CYC - 1;
            end
            cum += q_len[i];
        end
        return -1;
    endfunction

    function automatic int seg_index(input int k);
        int cum = 1;
        foreach (q_len[i]) begin
            if (k < cum + q_len[i]) return i;
            cum += q_len[i];
        end
        return q_len.size() - 1;
    endfunction

    task automatic seg_clear();
        q_row.delete();
        q_col.delete();
        q_len.delete();
    endtask

    task automatic seg_push(input logic [GS-1:0] r, input logic [GS-1:0] c, input int n);
        q_row.push_back(r);
        q_col.push_back(c);
        q_len.push_back(n);
    endtask

    // Drive the segment list under enable, expect one d_cap pulse on edge a+1
    task automatic run_frame(input string tag);
        logic [GS*GS-1:0] exp_frame;
        int a;
        int si;
        a = model_eval(exp_frame);
        if (a < 0) begin
            $display("FAIL %s: stimulus never completes a frame", tag);
            $fatal(1, "bad stimulus");
        end
        @(negedge clk);
        e_cap = 1'b1;
        row   = '0;
        col   = '0;
        @(posedge clk);
        for (int k = 1; k <= a + 3; k++) begin
            @(negedge clk);
            si    = seg_index((k > a) ? a : k);
            row   = q_row[si];
            col   = q_col[si];
            e_cap = (k <= a + 1);
            @(posedge clk);
            #1;
            chk({tag, "_dcap"}, 64'(d_cap), 64'(k == a + 1));
            if (k == a)     chk({tag, "_hold"},  matrix, prev_frame);
            if (k == a + 1) chk({tag, "_frame"}, matrix, exp_frame);
        end
        prev_frame = exp_frame;
    endtask

    // Drive the segment list, then drop enable: no frame may be published
    task automatic run_partial(input string tag);
        int total = 0;
        int si;
        foreach (q_len[i]) total += q_len[i];
        @(negedge clk);
        e_cap = 1'b1;
        row   = '0;
        col   = '0;
        @(posedge clk);
        for (int k = 1; k <= total + 4; k++) begin
            @(negedge clk);
            si    = seg_index((k > total) ? total : k);
            row   = q_row[si];
            col   = q_col[si];
            e_cap = (k <= total);
            @(posedge clk);
            #1;
            chk({tag, "_dcap"}, 64'(d_cap), 64'd0);
        end
        chk({tag, "_keep"}, matrix, prev_frame);
    endtask

    initial begin
        logic [GS-1:0] pat;
        logic [GS-1:0] pr;
        logic [GS-1:0] pc;
        logic [GS-1:0] rw;
        logic [GS-1:0] cl;
        logic [GS*GS-1:0] fr;
        int a;
        int sel;

        rst_n = 1'b1;
        e_cap = 1'b0;
        row   = '0;
        col   = '0;

        // Asynchronous reset applied mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_matrix", matrix, 64'd0);
        chk("rst_dcap", 64'(d_cap), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Full scan with a rotating 8'h81 pattern
        seg_clear();
        for (int r = 0; r < GS; r++) begin
            pat = 8'h81;
            pat = (pat << r) | (pat >> (GS - r));
            seg_push(GS'(1) << r, pat, 6);
        end
        run_frame("full");

        // Glitch: row 3 held 3 cycles then an illegal two-hot select
        seg_clear();
        for (int r = 0; r < 3; r++) seg_push(GS'(1) << r, GS'(8'h10 + r), 6);
        seg_push(GS'(1) << 3, 8'hC3, 3);
        seg_push(8'h0C, 8'hC3, 1);
        for (int r = 4; r < GS; r++) seg_push(GS'(1) << r, GS'(8'h20 + r), 6);
        seg_push(8'h00, 8'h00, 2);
        seg_push(GS'(1) << 3, 8'h3C, 5);
        run_frame("glitch");

        // Overwrite row 5 before the frame completes
        seg_clear();
        for (int r = 0; r < 5; r++) seg_push(GS'(1) << r, GS'(8'h01 << r), 6);
        seg_push(GS'(1) << 5, 8'hAA, 5);
        seg_push(GS'(1) << 5, 8'h55, 5);
        for (int r = 6; r < GS; r++) seg_push(GS'(1) << r, GS'(8'hF0 >> (r - 6)), 6);
        run_frame("overwrite");
        chk("overwrite_row5", 64'(matrix[47:40]), 64'h55);

        // Abort after 5 rows, then a fresh capture supplying only rows 5..7
        seg_clear();
        for (int r = 0; r < 5; r++) seg_push(GS'(1) << r, GS'(8'h5A ^ r), 6);
        run_partial("abort");
        seg_clear();
        for (int r = 5; r < GS; r++) seg_push(GS'(1) << r, GS'(8'hA5 ^ r), 6);
        run_partial("restart");

        // Reset in the middle of a capture
        @(negedge clk);
        e_cap = 1'b1;
        row   = GS'(1) << 2;
        col   = 8'h3C;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_matrix", matrix, 64'd0);
        chk("midrst_dcap", 64'(d_cap), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        @(negedge clk) e_cap = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        prev_frame = '0;

        // Blank input under enable: timeout build aborts, default build waits
        @(negedge clk);
        e_cap = 1'b1;
        row   = '0;
        col   = '0;
        @(posedge clk);
`ifdef FRAME_DECODER_TIMEOUT_EN
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            chk("tmo_err", 64'(err), 64'(k >= TIMEOUT));
            chk("tmo_dcap", 64'(d_cap), 64'd0);
        end
        @(negedge clk) e_cap = 1'b0;
        repeat (2) @(posedge clk);
`else
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            chk("notmo_err", 64'(err), 64'd0);
            chk("notmo_dcap", 64'(d_cap), 64'd0);
        end
`endif
        // Still capturing (default build): a frame now completes normally
        seg_clear();
        for (int r = GS - 1; r >= 0; r--) seg_push(GS'(1) << r, GS'(8'h11 * r), 5);
        run_frame("after_wait");

        // Randomized scans including blanking, glitches and short holds
        for (int f = 0; f < 6; f++) begin
            seg_clear();
            pr = '0;
            pc = '0;
            a  = -1;
            while (a < 0 && q_len.size() < 200) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       rw = GS'(1) << $urandom_range(0, GS - 1);
                else if (sel == 7) rw = '0;
                else               rw = GS'($urandom);
                cl = GS'($urandom);
                if (rw == pr && cl == pc) cl = ~cl;
                seg_push(rw, cl, $urandom_range(1, 7));
                pr = rw;
                pc = cl;
                a  = model_eval(fr);
            end
            run_frame($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
